// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the I2C configuration-write responder.
package i2c_cfg_pkg;

    localparam logic [7:0]  DevAddr      = 8'h34;
    localparam logic [6:0]  ResetRegAddr = 7'h0F;
    localparam int unsigned DataW        = 9;
    localparam int unsigned NumRegs      = 16;
    localparam int unsigned RegIdxW      = 4;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAckA,
        StByte1,
        StAck1,
        StByte2,
        StAck2,
        StWaitStop,
        StIgnore
    } state_e;

    // States in which a STOP truncates a word that has not been committed yet.
    function automatic logic in_word(input state_e s);
        return (s == StAddr) || (s == StAckA) || (s == StByte1) || (s == StAck1) ||
               (s == StByte2) || (s == StAck2);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into the system clock domain and flags edges, START and STOP.
module i2c_line_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic scl_meta_q, scl_sync_q, scl_hist_q;
    logic sda_meta_q, sda_sync_q, sda_hist_q;
    logic scl_rise_q, scl_fall_q, start_q, stop_q;

    // Lines reset to the idle-high level so leaving reset never looks like an edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_hist_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_hist_q <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_meta_q <= scl_i;
            scl_sync_q <= scl_meta_q;
            scl_hist_q <= scl_sync_q;
            sda_meta_q <= sda_i;
            sda_sync_q <= sda_meta_q;
            sda_hist_q <= sda_sync_q;
            scl_rise_q <= scl_sync_q & ~scl_hist_q;
            scl_fall_q <= ~scl_sync_q & scl_hist_q;
            start_q    <= scl_sync_q & scl_hist_q & sda_hist_q & ~sda_sync_q;
            stop_q     <= scl_sync_q & scl_hist_q & ~sda_hist_q & sda_sync_q;
        end
    end

    // sda_hist_q is the sample the registered event flags were computed from.
    assign sda_o      = sda_hist_q;
    assign scl_rise_o = scl_rise_q;
    assign scl_fall_o = scl_fall_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;

endmodule

// File: rtl/i2c_cfg_responder.sv
// I2C target that decodes 3-byte configuration writes and mirrors them in a shadow file.
module i2c_cfg_responder
    import i2c_cfg_pkg::*;
#(
    parameter logic [7:0] DevAddrCfg = DevAddr
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               i2c_sclk_i,
    input  logic               i2c_sdat_i,
    output logic               i2c_sdat_oe_o,
    output logic               word_valid_o,
    output logic [6:0]         reg_addr_o,
    output logic [DataW-1:0]   reg_data_o,
    output logic               bus_error_o,
    output logic               busy_o,
    input  logic [RegIdxW-1:0] rd_addr_i,
    output logic [DataW-1:0]   rd_data_o
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync u_line_sync (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .scl_i      (i2c_sclk_i),
        .sda_i      (i2c_sdat_i),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_det),
        .stop_o     (stop_det)
    );

    state_e           state_q;
    logic [2:0]       bit_cnt_q;
    logic             byte_done_q;
    logic [7:0]       shift_q;
    logic [7:0]       byte1_q;
    logic             oe_q;
    logic             word_valid_q;
    logic             bus_error_q;
    logic [6:0]       reg_addr_q;
    logic [DataW-1:0] reg_data_q;
    logic [DataW-1:0] rd_data_q;
    logic [DataW-1:0] shadow_q [NumRegs];

    logic       capturing;
    logic [6:0] commit_addr;

    assign capturing   = ((state_q == StAddr) || (state_q == StByte1) || (state_q == StByte2)) &&
                         !byte_done_q;
    assign commit_addr = byte1_q[7:1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            bit_cnt_q    <= 3'd0;
            byte_done_q  <= 1'b0;
            shift_q      <= 8'h00;
            byte1_q      <= 8'h00;
            oe_q         <= 1'b0;
            word_valid_q <= 1'b0;
            bus_error_q  <= 1'b0;
            reg_addr_q   <= 7'h00;
            reg_data_q   <= '0;
            rd_data_q    <= '0;
            for (int unsigned i = 0; i < NumRegs; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            word_valid_q <= 1'b0;
            bus_error_q  <= 1'b0;
            rd_data_q    <= shadow_q[rd_addr_i];

            if (start_det) begin
                state_q     <= StAddr;
                bit_cnt_q   <= 3'd0;
                byte_done_q <= 1'b0;
                oe_q        <= 1'b0;
            end else if (stop_det) begin
                bus_error_q <= in_word(state_q);
                state_q     <= StIdle;
                oe_q        <= 1'b0;
            end else if (scl_rise && capturing) begin
                shift_q   <= {shift_q[6:0], sda_s};
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    byte_done_q <= 1'b1;
                end
            end else if (scl_fall) begin
                case (state_q)
                    StAddr: begin
                        if (byte_done_q) begin
                            if (shift_q == DevAddrCfg) begin
                                state_q <= StAckA;
                                oe_q    <= 1'b1;
                            end else begin
                                state_q <= StIgnore;
                            end
                        end
                    end
                    StByte1: begin
                        if (byte_done_q) begin
                            byte1_q <= shift_q;
                            state_q <= StAck1;
                            oe_q    <= 1'b1;
                        end
                    end
                    StByte2: begin
                        if (byte_done_q) begin
                            state_q <= StAck2;
                            oe_q    <= 1'b1;
                        end
                    end
                    StAckA, StAck1: begin
                        state_q     <= (state_q == StAckA) ? StByte1 : StByte2;
                        oe_q        <= 1'b0;
                        bit_cnt_q   <= 3'd0;
                        byte_done_q <= 1'b0;
                    end
                    StAck2: begin
                        state_q      <= StWaitStop;
                        oe_q         <= 1'b0;
                        word_valid_q <= 1'b1;
                        reg_addr_q   <= commit_addr;
                        reg_data_q   <= {byte1_q[0], shift_q};
                        // The reset-register write wipes the file instead of being stored.
                        if (commit_addr == ResetRegAddr) begin
                            for (int unsigned i = 0; i < NumRegs; i++) begin
                                shadow_q[i] <= '0;
                            end
                        end else if (32'(commit_addr) < NumRegs) begin
                            shadow_q[commit_addr[RegIdxW-1:0]] <= {byte1_q[0], shift_q};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign i2c_sdat_oe_o = oe_q;
    assign word_valid_o  = word_valid_q;
    assign bus_error_o   = bus_error_q;
    assign reg_addr_o    = reg_addr_q;
    assign reg_data_o    = reg_data_q;
    assign rd_data_o     = rd_data_q;
    assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_i2c_cfg_responder.sv
// Self-checking bench for i2c_cfg_responder: directed vector table, corner sequences, random writes.
module tb_i2c_cfg_responder;

    localparam int H = 10;
    localparam int Q = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       m_scl, m_sda, bus_sda;
    logic       oe, word_valid, bus_error, busy;
    logic [6:0] reg_addr;
    logic [8:0] reg_data, rd_data;
    logic [3:0] rd_addr;

    assign bus_sda = m_sda & ~oe;

    always #5 clk = ~clk;

    i2c_cfg_responder dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .i2c_sclk_i    (m_scl),
        .i2c_sdat_i    (bus_sda),
        .i2c_sdat_oe_o (oe),
        .word_valid_o  (word_valid),
        .reg_addr_o    (reg_addr),
        .reg_data_o    (reg_data),
        .bus_error_o   (bus_error),
        .busy_o        (busy),
        .rd_addr_i     (rd_addr),
        .rd_data_o     (rd_data)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int wv_cnt   = 0;
    int be_cnt   = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (word_valid) wv_cnt++;
            if (bus_error) be_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wclk(H);
        m_scl = 1'b1; wclk(H);
        m_sda = 1'b0; wclk(H);
        m_scl = 1'b0; wclk(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wclk(Q);
        m_scl = 1'b1; wclk(H);
        m_sda = 1'b1; wclk(H);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;    wclk(Q);
        m_scl = 1'b1; wclk(H);
        m_scl = 1'b0; wclk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda = 1'b1; wclk(Q);
        m_scl = 1'b1; wclk(H / 2);
        @(negedge clk);
        ack = oe;
        wclk(H / 2);
        m_scl = 1'b0; wclk(Q);
    endtask

    task automatic xfer(input logic [7:0] dev, input logic [7:0] b1, input logic [7:0] b2,
                        input int nb, output int acks);
        logic a;
        acks = 0;
        i2c_start();
        send_byte(dev, a); acks += int'(a);
        if (nb >= 2) begin send_byte(b1, a); acks += int'(a); end
        if (nb >= 3) begin send_byte(b2, a); acks += int'(a); end
        i2c_stop();
    endtask

    task automatic read_reg(input logic [3:0] idx, output logic [8:0] val);
        @(negedge clk);
        rd_addr = idx;
        @(negedge clk);
        val = rd_data;
    endtask

    typedef struct {
        logic [7:0] dev, b1, b2;
        int         nb, acks, wv, be;
        logic [6:0] addr;
        logic [8:0] data;
        logic [3:0] rd_idx;
        logic [8:0] rd_val;
    } vec_t;

    vec_t       vecs [7];
    logic [8:0] ref_sh [16];
    logic [8:0] v;
    logic       a;
    int         acks, wv0, be0;

    initial begin
        vecs[0] = '{8'h34, 8'h0E, 8'h42, 3, 3, 1, 0, 7'h07, 9'h042, 4'd7, 9'h042};
        vecs[1] = '{8'h34, 8'h12, 8'h01, 3, 3, 1, 0, 7'h09, 9'h001, 4'd9, 9'h001};
        vecs[2] = '{8'h36, 8'h0E, 8'h42, 3, 0, 0, 0, 7'h09, 9'h001, 4'd7, 9'h042};
        vecs[3] = '{8'h34, 8'h08, 8'h00, 2, 2, 0, 1, 7'h09, 9'h001, 4'd4, 9'h000};
        vecs[4] = '{8'h34, 8'h09, 8'h55, 3, 3, 1, 0, 7'h04, 9'h155, 4'd4, 9'h155};
        vecs[5] = '{8'h34, 8'h1E, 8'h00, 3, 3, 1, 0, 7'h0F, 9'h000, 4'd9, 9'h000};
        vecs[6] = '{8'h34, 8'h26, 8'h77, 3, 3, 1, 0, 7'h13, 9'h077, 4'd3, 9'h000};

        rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; rd_addr = 4'd0;
        wclk(5);
        @(negedge clk);
        rst = 1'b0;
        wclk(2);
        @(negedge clk);
        check("reset oe", oe, 0);
        check("reset word_valid", word_valid, 0);
        check("reset bus_error", bus_error, 0);
        check("reset busy", busy, 0);
        check("reset reg_addr", reg_addr, 0);
        check("reset reg_data", reg_data, 0);
        check("reset rd_data", rd_data, 0);

        for (int i = 0; i < 7; i++) begin
            wv0 = wv_cnt; be0 = be_cnt;
            xfer(vecs[i].dev, vecs[i].b1, vecs[i].b2, vecs[i].nb, acks);
            @(negedge clk);
            check($sformatf("vec%0d acks", i), acks, vecs[i].acks);
            check($sformatf("vec%0d word_valid count", i), wv_cnt - wv0, vecs[i].wv);
            check($sformatf("vec%0d bus_error count", i), be_cnt - be0, vecs[i].be);
            check($sformatf("vec%0d reg_addr", i), reg_addr, vecs[i].addr);
            check($sformatf("vec%0d reg_data", i), reg_data, vecs[i].data);
            check($sformatf("vec%0d busy after stop", i), busy, 0);
            read_reg(vecs[i].rd_idx, v);
            check($sformatf("vec%0d readback", i), v, vecs[i].rd_val);
        end

        for (int i = 0; i < 16; i++) begin
            read_reg(4'(i), v);
            check($sformatf("cleared shadow[%0d]", i), v, 0);
        end

        // Fourth byte after a committed word is not acknowledged.
        wv0 = wv_cnt;
        i2c_start();
        send_byte(8'h34, a); check("seqA ack addr", a, 1);
        send_byte(8'h12, a); check("seqA ack b1", a, 1);
        send_byte(8'h01, a); check("seqA ack b2", a, 1);
        send_byte(8'hAA, a); check("seqA ack 4th byte", a, 0);
        i2c_stop();
        check("seqA word_valid count", wv_cnt - wv0, 1);
        check("seqA reg_data", reg_data, 9'h001);
        read_reg(4'd9, v); check("seqA shadow[9]", v, 9'h001);

        // Repeated START inside byte1 discards the partial word.
        wv0 = wv_cnt; be0 = be_cnt;
        i2c_start();
        send_byte(8'h34, a);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        i2c_start();
        send_byte(8'h34, a); check("seqC ack addr", a, 1);
        send_byte(8'h04, a); check("seqC ack b1", a, 1);
        send_byte(8'hFF, a); check("seqC ack b2", a, 1);
        @(negedge clk);
        check("seqC busy before stop", busy, 1);
        i2c_stop();
        check("seqC word_valid count", wv_cnt - wv0, 1);
        check("seqC bus_error count", be_cnt - be0, 0);
        check("seqC reg_addr", reg_addr, 7'h02);
        read_reg(4'd2, v); check("seqC shadow[2]", v, 9'h0FF);
        read_reg(4'd9, v); check("seqC shadow[9]", v, 9'h001);

        // Reset while the address ACK is being driven.
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(1'(8'h34 >> i));
        m_sda = 1'b1;
        wclk(2);
        @(negedge clk);
        check("seqD oe during ack", oe, 1);
        rst = 1'b1;
        @(negedge clk);
        check("seqD oe after rst", oe, 0);
        check("seqD busy after rst", busy, 0);
        check("seqD reg_addr after rst", reg_addr, 0);
        check("seqD reg_data after rst", reg_data, 0);
        check("seqD rd_data after rst", rd_data, 0);
        check("seqD word_valid after rst", word_valid, 0);
        m_scl = 1'b1; m_sda = 1'b1;
        wclk(5);
        @(negedge clk);
        rst = 1'b0;
        read_reg(4'd2, v); check("seqD shadow[2] after rst", v, 0);
        read_reg(4'd9, v); check("seqD shadow[9] after rst", v, 0);

        for (int i = 0; i < 16; i++) ref_sh[i] = 9'h000;
        begin
            logic [7:0] dev, b1, b2;
            logic [6:0] e_addr, ad;
            logic [8:0] e_data;
            logic [3:0] idx;
            int         nb, e_acks, e_wv, e_be;
            e_addr = 7'h00; e_data = 9'h000;
            for (int t = 0; t < 30; t++) begin
                dev = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h34;
                b1  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 31)) : 8'($urandom);
                b2  = 8'($urandom);
                nb  = ($urandom_range(0, 5) == 0) ? 2 : 3;
                e_acks = (dev == 8'h34) ? nb : 0;
                e_wv = 0; e_be = 0;
                if (dev == 8'h34 && nb == 2) e_be = 1;
                if (dev == 8'h34 && nb == 3) begin
                    e_wv = 1;
                    ad = b1[7:1];
                    e_addr = ad;
                    e_data = {b1[0], b2};
                    if (ad == 7'h0F) begin
                        for (int k = 0; k < 16; k++) ref_sh[k] = 9'h000;
                    end else if (ad < 7'd16) begin
                        ref_sh[ad[3:0]] = e_data;
                    end
                end
                wv0 = wv_cnt; be0 = be_cnt;
                xfer(dev, b1, b2, nb, acks);
                @(negedge clk);
                check($sformatf("rand%0d acks", t), acks, e_acks);
                check($sformatf("rand%0d word_valid count", t), wv_cnt - wv0, e_wv);
                check($sformatf("rand%0d bus_error count", t), be_cnt - be0, e_be);
                check($sformatf("rand%0d reg_addr", t), reg_addr, e_addr);
                check($sformatf("rand%0d reg_data", t), reg_data, e_data);
                idx = 4'($urandom);
                read_reg(idx, v);
                check($sformatf("rand%0d shadow[%0d]", t, idx), v, ref_sh[idx]);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
